// File: rtl/mem_responder_multicycle.sv
// -----------------------------------------------------------------------------
// mem_responder_multicycle
//
// Byte-addressed, little-endian memory responder for the multicycle RISC-V
// core. It accepts one request at a time, waits WAIT_CYCLES extra cycles, then
// performs the access and reports the result with a one-cycle ready pulse.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst    - asynchronous active-low reset (memory array is not cleared)
//   req    - request strobe, sampled only while idle
//   we     - 1 = write, 0 = read (latched with req)
//   addr   - byte address (latched with req)
//   wd     - right-aligned write data (latched with req)
//   dt     - access type: BYTE, HALF, WORD, UBYTE, UHALF, NONE (latched)
//   rd     - read data, sign/zero extended; 0 on writes and errors
//   ready  - one-cycle response pulse
//   err    - error flag, valid while ready is high; held afterwards
// -----------------------------------------------------------------------------

package mem_responder_multicycle_pkg;

  typedef enum logic [2:0] {
    BYTE  = 3'd0,
    HALF  = 3'd1,
    WORD  = 3'd2,
    UBYTE = 3'd3,
    UHALF = 3'd4,
    NONE  = 3'd5
  } mem_dt_e;

endpackage

module mem_responder_multicycle
  import mem_responder_multicycle_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  mem_dt_e     dt,
  output logic [31:0] rd,
  output logic        ready,
  output logic        err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  // S_RESP is the cycle in which the access is carried out; ready is the
  // registered result of that cycle, so it is visible one cycle later while
  // the FSM is already back in S_IDLE and able to take the next request.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wd_q;
  mem_dt_e       dt_q;
  logic [31:0]   rd_q;
  logic          ready_q;
  logic          err_q;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [AW-1:0] idx_d;
  logic [31:0]   word_d;
  logic [31:0]   wmerge_d;
  logic [31:0]   rext_d;
  logic          err_d;
  logic          mem_we_d;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Access-type / alignment check on the low address bits.
  function automatic logic f_type_err(input mem_dt_e t, input logic [1:0] a);
    logic bad;
    case (t)
      BYTE, UBYTE: bad = 1'b0;
      HALF, UHALF: bad = a[0];
      WORD:        bad = (a != 2'b00);
      default:     bad = 1'b1;  // NONE and unused encodings
    endcase
    return bad;
  endfunction

  // Byte-lane enables for a write of the given type at the given offset.
  function automatic logic [3:0] f_byte_en(input mem_dt_e t, input logic [1:0] a);
    logic [3:0] be;
    case (t)
      WORD:         be = 4'b1111;
      HALF, UHALF:  be = a[1] ? 4'b1100 : 4'b0011;
      BYTE, UBYTE:  be = 4'b0001 << a;
      default:      be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned write data so every candidate lane sees it.
  function automatic logic [31:0] f_align(input mem_dt_e t, input logic [31:0] d);
    logic [31:0] al;
    case (t)
      WORD:        al = d;
      HALF, UHALF: al = {2{d[15:0]}};
      BYTE, UBYTE: al = {4{d[7:0]}};
      default:     al = 32'h0000_0000;
    endcase
    return al;
  endfunction

  // Merge new lanes into the stored word; untouched lanes keep old contents.
  function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return m;
  endfunction

  // Select the addressed byte/half and extend it to 32 bits.
  function automatic logic [31:0] f_extend(input mem_dt_e t, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    sh = w >> {a, 3'b000};
    b  = sh[7:0];
    h  = a[1] ? w[31:16] : w[15:0];
    case (t)
      BYTE:    r = {{24{b[7]}}, b};
      UBYTE:   r = {24'h00_0000, b};
      HALF:    r = {{16{h[15]}}, h};
      UHALF:   r = {16'h0000, h};
      WORD:    r = w;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------

  // Decode the latched request against the currently stored word.
  always_comb begin
    idx_d    = addr_q[AW+1:2];
    word_d   = mem_q[idx_d];
    // Upper address bits must be zero: out-of-range words are never aliased.
    err_d    = f_type_err(dt_q, addr_q[1:0]) | (|addr_q[31:AW+2]);
    wmerge_d = f_merge(word_d, f_align(dt_q, wd_q), f_byte_en(dt_q, addr_q[1:0]));
    rext_d   = f_extend(dt_q, addr_q[1:0], word_d);
    if ((state_q == S_RESP) && we_q && !err_d) begin
      mem_we_d = 1'b1;
    end else begin
      mem_we_d = 1'b0;
    end
  end

  // Storage array: not reset, written only by an error-free write in S_RESP.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[idx_d] <= wmerge_d;
    end
  end

  // Control FSM with request latch, wait counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wd_q    <= 32'h0000_0000;
      dt_q    <= NONE;
      rd_q    <= 32'h0000_0000;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wd_q    <= wd;
            dt_q    <= dt;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt_q <= 4'd1) begin
            cnt_q   <= 4'd0;
            state_q <= S_RESP;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          ready_q <= 1'b1;
          err_q   <= err_d;
          rd_q    <= (err_d || we_q) ? 32'h0000_0000 : rext_d;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  assign rd    = rd_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule
